// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: function codes, FSM states
// and small opcode classification helpers.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADDS = 4'b0000;
    localparam logic [3:0] OP_ADDU = 4'b0001;
    localparam logic [3:0] OP_SUBS = 4'b0010;
    localparam logic [3:0] OP_SUBU = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_NOR  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_SLL  = 4'b1010;
    localparam logic [3:0] OP_BREV = 4'b1011;
    localparam logic [3:0] OP_NOT  = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1101;
    localparam logic [3:0] OP_ILL0 = 4'b1110;
    localparam logic [3:0] OP_ILL1 = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    function automatic logic is_shift(input logic [3:0] code);
        return (code == OP_SRL) || (code == OP_SRA) || (code == OP_SLL);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle functions (add/sub/logic/BREV/NOT/illegal)
// together with their carry, negative, overflow and error flags.
module alu_core #(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             neg,
    output logic             carry,
    output logic             ovfl,
    output logic             op_err
);
    import alu_seq_pkg::*;

    logic             sub_s;
    logic [WIDTH-1:0] bx_s;
    logic [WIDTH:0]   sum_s;
    logic             sov_s;

    // Shared adder; subtraction is a + ~b + 1 so carry-out means "no borrow"
    always_comb begin
        sub_s = (op == OP_SUBS) || (op == OP_SUBU);
        bx_s  = sub_s ? ~b : b;
        sum_s = {1'b0, a} + {1'b0, bx_s} + {{WIDTH{1'b0}}, sub_s};
        sov_s = (a[WIDTH-1] == bx_s[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
    end

    // Function select and flag generation
    always_comb begin
        result = {WIDTH{1'b0}};
        carry  = 1'b0;
        ovfl   = 1'b0;
        op_err = 1'b0;
        case (op)
            OP_ADDS, OP_SUBS: begin
                result = sum_s[WIDTH-1:0];
                carry  = sum_s[WIDTH];
                ovfl   = sov_s;
            end
            OP_ADDU: begin
                result = sum_s[WIDTH-1:0];
                carry  = sum_s[WIDTH];
                ovfl   = sum_s[WIDTH];
            end
            OP_SUBU: begin
                result = sum_s[WIDTH-1:0];
                carry  = sum_s[WIDTH];
                ovfl   = ~sum_s[WIDTH];
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOR:  result = ~(a | b);
            OP_BREV: begin
                for (int i = 0; i < WIDTH / 8; i++) begin
                    result[8*i +: 8] = a[WIDTH-8-8*i +: 8];
                end
            end
            OP_NOT:  result = ~a;
            OP_ILL0, OP_ILL1: op_err = 1'b1;
            default: result = {WIDTH{1'b0}};
        endcase
        // Unsigned add/sub report carry/borrow on neg, which equals ovfl there
        if ((op == OP_ADDU) || (op == OP_SUBU)) begin
            neg = ovfl;
        end else begin
            neg = result[WIDTH-1];
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: valid/ready handshaked, one operation in flight,
// iterative shifts (one bit per cycle) and shift-add multiply.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg,
    output logic             carry,
    output logic             ovfl,
    output logic             op_err
);
    import alu_seq_pkg::*;

    localparam logic [SHW-1:0] CNT_ZERO = {SHW{1'b0}};
    localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);
    localparam logic [SHW-1:0] MUL_LAST = SHW'(WIDTH - 1);

    state_t           state_r;
    logic [3:0]       op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc_r;
    logic [SHW-1:0]   cnt_r;

    logic [WIDTH-1:0] core_res_s;
    logic             core_neg_s;
    logic             core_carry_s;
    logic             core_ovfl_s;
    logic             core_err_s;
    logic [WIDTH-1:0] shift_s;
    logic             shift_c_s;
    logic [WIDTH-1:0] acc_next_s;
    logic [WIDTH-1:0] fin_res_s;
    logic             fin_neg_s;
    logic             fin_carry_s;
    logic             fin_ovfl_s;
    logic             fin_err_s;
    logic             fin_last_s;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op     (op_r),
        .a      (a_r),
        .b      (b_r),
        .result (core_res_s),
        .neg    (core_neg_s),
        .carry  (core_carry_s),
        .ovfl   (core_ovfl_s),
        .op_err (core_err_s)
    );

    // One-bit shift step and one multiply step on the working registers
    always_comb begin
        case (op_r)
            OP_SRL: begin
                shift_s   = {1'b0, a_r[WIDTH-1:1]};
                shift_c_s = a_r[0];
            end
            OP_SRA: begin
                shift_s   = {a_r[WIDTH-1], a_r[WIDTH-1:1]};
                shift_c_s = a_r[0];
            end
            OP_SLL: begin
                shift_s   = {a_r[WIDTH-2:0], 1'b0};
                shift_c_s = a_r[WIDTH-1];
            end
            default: begin
                shift_s   = a_r;
                shift_c_s = 1'b0;
            end
        endcase
        if (b_r[0]) begin
            acc_next_s = acc_r + a_r;
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Result/flags to commit when the current BUSY cycle is the last one
    always_comb begin
        fin_res_s   = core_res_s;
        fin_neg_s   = core_neg_s;
        fin_carry_s = core_carry_s;
        fin_ovfl_s  = core_ovfl_s;
        fin_err_s   = core_err_s;
        fin_last_s  = 1'b1;
        if (is_shift(op_r)) begin
            // A zero shift amount completes at once with the operand untouched
            if (cnt_r == CNT_ZERO) begin
                fin_res_s   = a_r;
                fin_carry_s = 1'b0;
            end else begin
                fin_res_s   = shift_s;
                fin_carry_s = shift_c_s;
            end
            fin_neg_s  = fin_res_s[WIDTH-1];
            fin_ovfl_s = 1'b0;
            fin_err_s  = 1'b0;
            fin_last_s = (cnt_r <= CNT_ONE);
        end else if (op_r == OP_MUL) begin
            fin_res_s   = acc_next_s;
            fin_neg_s   = acc_next_s[WIDTH-1];
            fin_carry_s = 1'b0;
            fin_ovfl_s  = 1'b0;
            fin_err_s   = 1'b0;
            fin_last_s  = (cnt_r == CNT_ZERO);
        end else begin
            fin_last_s = 1'b1;
        end
    end

    // Control FSM, operand/iteration registers and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= {WIDTH{1'b0}};
            zero      <= 1'b0;
            neg       <= 1'b0;
            carry     <= 1'b0;
            ovfl      <= 1'b0;
            op_err    <= 1'b0;
            op_r      <= 4'b0000;
            a_r       <= {WIDTH{1'b0}};
            b_r       <= {WIDTH{1'b0}};
            acc_r     <= {WIDTH{1'b0}};
            cnt_r     <= CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_r     <= op;
                        a_r      <= a;
                        b_r      <= b;
                        acc_r    <= {WIDTH{1'b0}};
                        cnt_r    <= (op == OP_MUL) ? MUL_LAST : b[SHW-1:0];
                        in_ready <= 1'b0;
                        state_r  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (is_shift(op_r) && (cnt_r != CNT_ZERO)) begin
                        a_r   <= shift_s;
                        cnt_r <= cnt_r - CNT_ONE;
                    end else if (op_r == OP_MUL) begin
                        acc_r <= acc_next_s;
                        a_r   <= {a_r[WIDTH-2:0], 1'b0};
                        b_r   <= {1'b0, b_r[WIDTH-1:1]};
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                    if (fin_last_s) begin
                        state_r   <= ST_DONE;
                        out_valid <= 1'b1;
                        result    <= fin_res_s;
                        zero      <= (fin_res_s == {WIDTH{1'b0}});
                        neg       <= fin_neg_s;
                        carry     <= fin_carry_s;
                        ovfl      <= fin_ovfl_s;
                        op_err    <= fin_err_s;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r   <= ST_IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        op_err    <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vector table, handshake and
// reset corner sequences, and random operations against a behavioural model.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        neg;
    logic        carry;
    logic        ovfl;
    logic        op_err;

    int n_vec = 0;
    int n_bad = 0;

    alu_seq #(.WIDTH(32), .SHW(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .neg       (neg),
        .carry     (carry),
        .ovfl      (ovfl),
        .op_err    (op_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [4:0]  flags;   // {zero, neg, carry, ovfl, op_err}
        int          lat;     // clock edges from accept edge (inclusive) to out_valid
    } vec_t;

    vec_t tbl [15];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model from the arithmetic definition of each function
    function automatic void model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [4:0] f, output int lat);
        logic [32:0] w;
        longint      s;
        int          n;
        logic        c;
        logic        v;
        logic        ng;
        logic        e;
        n = int'(y[4:0]);
        c = 1'b0; v = 1'b0; e = 1'b0; lat = 2; r = 32'h0;
        case (o)
            4'd0, 4'd1: begin
                w = {1'b0, x} + {1'b0, y};
                r = w[31:0];
                c = w[32];
                s = longint'($signed(x)) + longint'($signed(y));
                v = (o == 4'd0) ? ((s > 64'sd2147483647) || (s < -64'sd2147483648)) : c;
            end
            4'd2, 4'd3: begin
                r = x - y;
                c = (x >= y);
                s = longint'($signed(x)) - longint'($signed(y));
                v = (o == 4'd2) ? ((s > 64'sd2147483647) || (s < -64'sd2147483648)) : !c;
            end
            4'd4:  r = x & y;
            4'd5:  r = x | y;
            4'd6:  r = x ^ y;
            4'd7:  r = ~(x | y);
            4'd8:  begin r = x >> n; c = (n == 0) ? 1'b0 : x[n-1]; end
            4'd9:  begin r = $signed(x) >>> n; c = (n == 0) ? 1'b0 : x[n-1]; end
            4'd10: begin r = x << n; c = (n == 0) ? 1'b0 : x[32-n]; end
            4'd11: r = {x[7:0], x[15:8], x[23:16], x[31:24]};
            4'd12: r = ~x;
            4'd13: begin r = x * y; lat = 33; end
            default: begin r = 32'h0; e = 1'b1; end
        endcase
        if ((o >= 4'd8) && (o <= 4'd10)) lat = 1 + ((n == 0) ? 1 : n);
        if (o == 4'd1)      ng = c;
        else if (o == 4'd3) ng = !c;
        else                ng = r[31];
        f = {(r == 32'h0), ng, c, v, e};
    endfunction

    // Issue one op, wait for the result, optionally stall the consumer, then release
    task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input int hold,
                          output logic [31:0] r, output logic [4:0] f, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 4'($urandom_range(0, 15)); a = $urandom; b = $urandom;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        r = result;
        f = {zero, neg, carry, ovfl, op_err};
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            check("hold result", 64'(result), 64'(r));
            check("hold flags", 64'({zero, neg, carry, ovfl, op_err}), 64'(f));
            check("hold in_ready", 64'(in_ready), 64'd0);
            check("hold out_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release in_ready", 64'(in_ready), 64'd1);
        check("release out_valid", 64'(out_valid), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] er;
        logic [4:0]  f;
        logic [4:0]  ef;
        int          lat;
        int          elat;
        logic [3:0]  ro;

        tbl[0]  = '{4'h0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 5'b01010, 2};
        tbl[1]  = '{4'h3, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 5'b01010, 2};
        tbl[2]  = '{4'h2, 32'h00000005, 32'h00000005, 32'h00000000, 5'b10100, 2};
        tbl[3]  = '{4'h9, 32'h80000000, 32'h00000004, 32'hF8000000, 5'b01000, 5};
        tbl[4]  = '{4'hA, 32'h12345678, 32'h00000000, 32'h12345678, 5'b00000, 2};
        tbl[5]  = '{4'hD, 32'h00010001, 32'h00010001, 32'h00020001, 5'b00000, 33};
        tbl[6]  = '{4'hB, 32'h11223344, 32'h00000000, 32'h44332211, 5'b00000, 2};
        tbl[7]  = '{4'h1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'b11110, 2};
        tbl[8]  = '{4'hA, 32'h80000001, 32'h00000001, 32'h00000002, 5'b00100, 2};
        tbl[9]  = '{4'h8, 32'h00000003, 32'h00000001, 32'h00000001, 5'b00100, 2};
        tbl[10] = '{4'h7, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 5'b01000, 2};
        tbl[11] = '{4'hE, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 5'b10001, 2};
        tbl[12] = '{4'hC, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 5'b10000, 2};
        tbl[13] = '{4'hA, 32'h00000001, 32'h0000001F, 32'h80000000, 5'b01000, 32};
        tbl[14] = '{4'h2, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 5'b00110, 2};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 4'h0; a = 32'h0; b = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset result", 64'(result), 64'd0);
        check("reset flags", 64'({zero, neg, carry, ovfl, op_err}), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, 0, r, f, lat);
            check($sformatf("vec%0d result", i), 64'(r), 64'(tbl[i].res));
            check($sformatf("vec%0d flags", i), 64'(f), 64'(tbl[i].flags));
            check($sformatf("vec%0d latency", i), 64'(lat), 64'(tbl[i].lat));
        end

        // Reset in the middle of a multiply discards it and clears the outputs
        op = 4'hD; a = 32'h00001234; b = 32'h00005678; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("midreset out_valid", 64'(out_valid), 64'd0);
        check("midreset result", 64'(result), 64'd0);
        check("midreset flags", 64'({zero, neg, carry, ovfl, op_err}), 64'd0);
        check("midreset in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("discarded out_valid", 64'(out_valid), 64'd0);
        run_op(4'hF, 32'hDEADBEEF, 32'h00000003, 0, r, f, lat);
        check("illegal result", 64'(r), 64'd0);
        check("illegal flags", 64'(f), 64'(5'b10001));
        check("illegal latency", 64'(lat), 64'd2);

        // Consumer stall with new requests pending, then release
        run_op(4'h0, 32'h00000001, 32'h00000002, 5, r, f, lat);
        check("stall result", 64'(r), 64'd3);
        check("stall flags", 64'(f), 64'd0);
        run_op(4'h4, 32'hF0F0F0F0, 32'hFF00FF00, 0, r, f, lat);
        check("after stall result", 64'(r), 64'(32'hF000F000));

        for (int i = 0; i < 40; i++) begin
            ro = 4'($urandom_range(0, 15));
            a = $urandom; b = $urandom;
            model(ro, a, b, er, ef, elat);
            run_op(ro, a, b, int'($urandom_range(0, 2)), r, f, lat);
            check($sformatf("rand%0d op%0h result", i, ro), 64'(r), 64'(er));
            check($sformatf("rand%0d op%0h flags", i, ro), 64'(f), 64'(ef));
            check($sformatf("rand%0d op%0h latency", i, ro), 64'(lat), 64'(elat));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
